// File: rtl/ldst_controller.sv
// ldst_controller: sequences one LD/ST request at a time between decode, the register file and RAM
module ldst_controller #(
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_rb_sel,
  input  logic [3:0]        req_offset,
  output logic [1:0]        rf_rd_sel,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [1:0]        rf_wr_sel,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  ld_count,
  output logic [CNT_W-1:0]  st_count
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RF_READ   = 3'd1;
  localparam logic [2:0] MEM_WRITE = 3'd2;
  localparam logic [2:0] MEM_READ  = 3'd3;
  localparam logic [2:0] WRITEBACK = 3'd4;
  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [1:0]        rb_sel;
  logic [DATA_W-1:0] addr;
  logic [2:0]        wait_cnt;
  logic              accept;
  logic              last_wait;
  assign req_ready = (state == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  assign last_wait = wait_cnt == 3'(MEM_LAT - 1);
  assign busy      = state != IDLE;
  assign rf_rd_sel = rb_sel;
  assign mem_addr  = busy ? addr : '0;
  // strobes are gated with rst so an aborted operation never writes
  assign mem_we     = (state == MEM_WRITE) & ~rst;
  assign rf_wr_en   = (state == WRITEBACK) & ~rst;
  assign done       = mem_we | rf_wr_en;
  assign rf_wr_sel  = (state == WRITEBACK) ? rb_sel : 2'd0;
  assign rf_wr_data = (state == WRITEBACK) ? mem_rdata : '0;
  always_comb begin
    state_nxt = (state == IDLE)     ? (accept ? (req_is_store ? RF_READ : MEM_READ) : IDLE) :
                (state == RF_READ)  ? MEM_WRITE :
                (state == MEM_READ) ? (last_wait ? WRITEBACK : MEM_READ) :
                IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rb_sel    <= 2'd0;
      addr      <= '0;
      wait_cnt  <= 3'd0;
      mem_wdata <= '0;
      ld_count  <= '0;
      st_count  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rb_sel   <= req_rb_sel;
        addr     <= {{(DATA_W-4){req_offset[3]}}, req_offset};
        wait_cnt <= 3'd0;
      end
      if (state == MEM_READ) wait_cnt <= wait_cnt + 3'd1;
      if (state == RF_READ) mem_wdata <= rf_rd_data;
      if (state == MEM_WRITE) st_count <= st_count + 1'b1;
      if (state == WRITEBACK) ld_count <= ld_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_ldst_controller.sv
// tb_ldst_controller: vector table, hand-written corner sequences and random ops against a transaction model
module tb_ldst_controller;
  localparam int MEM_LAT = 3;
  logic       clk = 0;
  logic       rst = 1;
  logic       req_valid = 0;
  logic       req_ready;
  logic       req_is_store = 0;
  logic [1:0] req_rb_sel = 0;
  logic [3:0] req_offset = 0;
  logic [1:0] rf_rd_sel;
  logic [7:0] rf_rd_data;
  logic       rf_wr_en;
  logic [1:0] rf_wr_sel;
  logic [7:0] rf_wr_data;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;
  logic [7:0] ld_count;
  logic [7:0] st_count;
  int tests = 0;
  int fails = 0;
  logic [7:0] rf [4];
  logic [7:0] ram [256];
  logic [7:0] a1 = 0, a2 = 0, a3 = 0;
  logic [7:0] m_rf [4];
  logic [7:0] m_ram [256];
  int m_ld = 0;
  int m_st = 0;

  ldst_controller #(.DATA_W(8), .MEM_LAT(MEM_LAT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_rb_sel(req_rb_sel), .req_offset(req_offset),
    .rf_rd_sel(rf_rd_sel), .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en),
    .rf_wr_sel(rf_wr_sel), .rf_wr_data(rf_wr_data), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .ld_count(ld_count), .st_count(st_count)
  );

  always #5 clk = ~clk;
  assign rf_rd_data = rf[rf_rd_sel];
  assign mem_rdata  = ram[a3];
  always @(posedge clk) begin
    a1 <= mem_addr;
    a2 <= a1;
    a3 <= a2;
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (rf_wr_en) rf[rf_wr_sel] <= rf_wr_data;
  end

  typedef struct {
    logic       st;
    logic [1:0] rb;
    logic [3:0] off;
    logic [7:0] ea;
    logic [7:0] ed;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic [7:0] sext(input logic [3:0] off);
    return 8'(off >= 4'd8 ? int'(off) + 240 : int'(off));
  endfunction

  task automatic check_idle_zero(input string n);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
    chk({n, "_mem_we"}, mem_we, 0);
    chk({n, "_rf_wr_en"}, rf_wr_en, 0);
    chk({n, "_mem_addr"}, mem_addr, 0);
    chk({n, "_rf_wr_sel"}, rf_wr_sel, 0);
    chk({n, "_rf_wr_data"}, rf_wr_data, 0);
    chk({n, "_ld_count"}, ld_count, 0);
    chk({n, "_st_count"}, st_count, 0);
  endtask

  task automatic do_op(input logic st, input logic [1:0] rb, input logic [3:0] off,
                       input logic [7:0] ea, input logic [7:0] ed);
    int lat;
    int k;
    lat = st ? 2 : MEM_LAT + 1;
    @(negedge clk);
    req_valid = 1; req_is_store = st; req_rb_sel = rb; req_offset = off;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept_wait", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk("op_busy", busy, 1);
      chk("op_addr", mem_addr, ea);
      if (c < lat) chk("op_early_strobe", {mem_we, rf_wr_en, done}, 0);
      else begin
        chk("op_done", done, 1);
        chk("op_mem_we", mem_we, st);
        chk("op_rf_wr_en", rf_wr_en, !st);
        if (st) chk("op_wdata", mem_wdata, ed);
        else begin
          chk("op_wr_sel", rf_wr_sel, rb);
          chk("op_wr_data", rf_wr_data, ed);
        end
      end
    end
    if (st) begin m_ram[ea] = ed; m_st++; end
    else begin m_rf[rb] = ed; m_ld++; end
    @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_ready", req_ready, 1);
    chk("post_done", done, 0);
    chk("post_addr", mem_addr, 0);
    chk("post_st_count", st_count, m_st % 256);
    chk("post_ld_count", ld_count, m_ld % 256);
  endtask

  initial begin
    int first_ready, wr_cyc, we_cyc, nwr, nwe, k;
    logic [7:0] wd, ld_exp, st_exp;
    logic st;
    logic [1:0] rb;
    logic [3:0] off;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'(i) ^ 8'h3C;
      m_ram[i] = 8'(i) ^ 8'h3C;
    end
    ram[8'hFE] = 8'hC3; m_ram[8'hFE] = 8'hC3;
    rf[0] = 8'h11; rf[1] = 8'h22; rf[2] = 8'h5A; rf[3] = 8'hA5;
    for (int i = 0; i < 4; i++) m_rf[i] = rf[i];
    tbl[0] = '{1'b1, 2'd2, 4'h3, 8'h03, 8'h5A};
    tbl[1] = '{1'b0, 2'd1, 4'hE, 8'hFE, 8'hC3};
    tbl[2] = '{1'b1, 2'd1, 4'h8, 8'hF8, 8'hC3};
    tbl[3] = '{1'b1, 2'd3, 4'h7, 8'h07, 8'hA5};
    tbl[4] = '{1'b0, 2'd0, 4'h3, 8'h03, 8'h5A};
    tbl[5] = '{1'b0, 2'd2, 4'h8, 8'hF8, 8'hC3};

    // reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    check_idle_zero("rst");
    rst = 0;
    #1;
    chk("rel_ready", req_ready, 1);
    check_idle_zero("rel");
    chk("rel_rd_sel", rf_rd_sel, 0);
    chk("rel_wdata", mem_wdata, 0);

    foreach (tbl[i]) do_op(tbl[i].st, tbl[i].rb, tbl[i].off, tbl[i].ea, tbl[i].ed);

    // second request held from cycle 1 of a load
    ld_exp = m_ram[8'h02];
    @(negedge clk);
    req_valid = 1; req_is_store = 0; req_rb_sel = 2'd3; req_offset = 4'h2;
    chk("busy_seq_ready0", req_ready, 1);
    @(posedge clk);
    #1 req_is_store = 1; req_rb_sel = 2'd0; req_offset = 4'h5;
    st_exp = ld_exp;
    first_ready = 0; wr_cyc = 0; we_cyc = 0; nwr = 0; nwe = 0; wd = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rf_wr_en) begin nwr++; wr_cyc = c; end
      if (mem_we) begin nwe++; we_cyc = c; wd = mem_wdata; end
      if (rf_wr_en && mem_we) chk("busy_seq_overlap", 1, 0);
      if (c == 4) st_exp = m_rf[0];
      if (req_ready && first_ready == 0) begin
        first_ready = c;
        @(posedge clk);
        #1 req_valid = 0;
      end
    end
    chk("busy_seq_wr_cyc", wr_cyc, MEM_LAT + 1);
    chk("busy_seq_next_accept", first_ready, MEM_LAT + 2);
    chk("busy_seq_we_cyc", we_cyc, MEM_LAT + 4);
    chk("busy_seq_nwr", nwr, 1);
    chk("busy_seq_nwe", nwe, 1);
    chk("busy_seq_wdata", wd, st_exp);
    m_rf[3] = ld_exp; m_ld++;
    m_ram[8'h05] = st_exp; m_st++;
    chk("busy_seq_ld_count", ld_count, m_ld % 256);
    chk("busy_seq_st_count", st_count, m_st % 256);
    chk("busy_seq_rf3", rf[3], ld_exp);

    for (int i = 0; i < 40; i++) begin
      st  = 1'($urandom_range(0, 1));
      rb  = 2'($urandom_range(0, 3));
      off = 4'($urandom_range(0, 15));
      do_op(st, rb, off, sext(off), st ? m_rf[rb] : m_ram[sext(off)]);
    end

    // reset during MEM_READ aborts the load
    @(negedge clk);
    req_valid = 1; req_is_store = 0; req_rb_sel = 2'd1; req_offset = 4'h4;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_busy", busy, 1);
    rst = 1;
    #1;
    chk("midrst_ready", req_ready, 0);
    chk("midrst_strobes", {mem_we, rf_wr_en, done}, 0);
    @(negedge clk);
    rst = 0;
    m_ld = 0; m_st = 0;
    #1;
    check_idle_zero("midrst_after");
    chk("midrst_after_ready", req_ready, 1);
    nwr = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rf_wr_en || done || busy) nwr++;
    end
    chk("midrst_no_activity", nwr, 0);

    do_op(1'b0, 2'd2, 4'h9, 8'hF9, m_ram[8'hF9]);
    for (int i = 0; i < 256; i++) begin
      rb  = 2'($urandom_range(0, 3));
      off = 4'($urandom_range(0, 15));
      do_op(1'b1, rb, off, sext(off), m_rf[rb]);
    end
    chk("wrap_st_count", st_count, 0);
    chk("wrap_ld_count", ld_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
